// File: rtl/clock_digits_renderer_if.sv
// ----------------------------------------------------------------------------
// clock_digits_renderer_if
//   Pixel-stream bundle between the VGA timing generator (master) and the
//   clock digit renderer (slave).
//
//   h_disp, v_disp : visible-region flags for the current pixel
//   pos_x, pos_y   : current pixel coordinates
//   digits_in      : BCD digits, digit 0 (leftmost) in [3:0]
//   blink_mask     : 1 = that digit blinks
//   sep_en         : enable the colons between digit pairs
//   r_out/g_out/b_out : rendered colour, two pixel clocks behind the inputs
// ----------------------------------------------------------------------------
interface clock_digits_renderer_if #(
    parameter int NUM_DIGITS = 6,
    parameter int POS_W      = 11,
    parameter int COLOR_W    = 1
);
    logic                    h_disp;
    logic                    v_disp;
    logic [POS_W-1:0]        pos_x;
    logic [POS_W-1:0]        pos_y;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    sep_en;
    logic [COLOR_W-1:0]      r_out;
    logic [COLOR_W-1:0]      g_out;
    logic [COLOR_W-1:0]      b_out;

    modport master (
        output h_disp, v_disp, pos_x, pos_y, digits_in, blink_mask, sep_en,
        input  r_out, g_out, b_out
    );

    modport slave (
        input  h_disp, v_disp, pos_x, pos_y, digits_in, blink_mask, sep_en,
        output r_out, g_out, b_out
    );
endinterface

// File: rtl/clock_digits_renderer.sv
// ----------------------------------------------------------------------------
// clock_digits_renderer
//   Draws NUM_DIGITS seven-segment BCD digits as block glyphs at a fixed
//   screen origin, with optional blinking colons after odd digits and
//   per-digit blink. Digit values are latched at the falling edge of v_disp
//   so a frame never shows a half-updated time. Two-stage pixel pipeline.
//
//   clk     : pixel clock
//   reset_n : asynchronous active-low reset
//   bus     : pixel-stream interface (slave side), see clock_digits_renderer_if
// ----------------------------------------------------------------------------
module clock_digits_renderer #(
    parameter int                 NUM_DIGITS   = 6,
    parameter int                 BLOCK_SIZE   = 5,
    parameter int                 DIGIT_PITCH  = 30,
    parameter int                 ORIGIN_X     = 400,
    parameter int                 ORIGIN_Y     = 340,
    parameter int                 POS_W        = 11,
    parameter int                 COLOR_W      = 1,
    parameter logic [COLOR_W-1:0] FG_R         = '1,
    parameter logic [COLOR_W-1:0] FG_G         = '1,
    parameter logic [COLOR_W-1:0] FG_B         = '1,
    parameter logic [COLOR_W-1:0] BG_R         = '0,
    parameter logic [COLOR_W-1:0] BG_G         = '0,
    parameter logic [COLOR_W-1:0] BG_B         = '0,
    parameter int                 BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    reset_n,
    clock_digits_renderer_if.slave  bus
);

    localparam int               CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // True when (x,y) lies inside cell columns c0..c1 and rows r0..r1 of a
    // digit whose left edge is dx. All bounds fold to constants.
    function automatic logic in_box(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y,
                                    input int dx, input int c0, input int c1,
                                    input int r0, input int r1);
        return (x >= POS_W'(dx + c0 * BLOCK_SIZE))       &&
               (x <  POS_W'(dx + (c1 + 1) * BLOCK_SIZE)) &&
               (y >= POS_W'(ORIGIN_Y + r0 * BLOCK_SIZE)) &&
               (y <  POS_W'(ORIGIN_Y + (r1 + 1) * BLOCK_SIZE));
    endfunction

    // Segment pattern {a,b,c,d,e,f,g}; codes 10..15 render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return 7'h7E;
            4'd1:    return 7'h30;
            4'd2:    return 7'h6D;
            4'd3:    return 7'h79;
            4'd4:    return 7'h33;
            4'd5:    return 7'h5B;
            4'd6:    return 7'h5F;
            4'd7:    return 7'h70;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    // ---------------- frame latch and blink timing ----------------
    logic                    r_v_d;
    logic                    w_frame_end;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_blink_mask;
    logic                    r_sep_en;
    logic [CNT_W-1:0]        r_blink_cnt;
    logic                    r_blink_phase;

    assign w_frame_end = r_v_d & ~bus.v_disp;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v_d         <= 1'b0;
            // NOTE: the shadow digits are reset (to blank) because the screen
            // must show nothing until the first frame has been latched.
            r_digits      <= '1;
            r_blink_mask  <= '0;
            r_sep_en      <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_v_d <= bus.v_disp;
            if (w_frame_end) begin
                r_digits     <= bus.digits_in;
                r_blink_mask <= bus.blink_mask;
                r_sep_en     <= bus.sep_en;
                // Phase flips together with the shadow load, so the new
                // phase and the new digits belong to the same frame.
                if (r_blink_cnt == CNT_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- per-digit hit detection ----------------
    logic [NUM_DIGITS-1:0] w_hit;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam int DX = ORIGIN_X + k * DIGIT_PITCH;
        logic [6:0] w_seg;
        logic       w_seg_hit;
        logic       w_colon_hit;

        assign w_seg = (r_blink_mask[k] & r_blink_phase) ? 7'h00
                                                          : seg_decode(r_digits[4*k +: 4]);

        assign w_seg_hit =
            (w_seg[6] & in_box(bus.pos_x, bus.pos_y, DX, 1, 3, 0, 0)) |  // a
            (w_seg[5] & in_box(bus.pos_x, bus.pos_y, DX, 4, 4, 1, 3)) |  // b
            (w_seg[4] & in_box(bus.pos_x, bus.pos_y, DX, 4, 4, 5, 7)) |  // c
            (w_seg[3] & in_box(bus.pos_x, bus.pos_y, DX, 1, 3, 8, 8)) |  // d
            (w_seg[2] & in_box(bus.pos_x, bus.pos_y, DX, 0, 0, 5, 7)) |  // e
            (w_seg[1] & in_box(bus.pos_x, bus.pos_y, DX, 0, 0, 1, 3)) |  // f
            (w_seg[0] & in_box(bus.pos_x, bus.pos_y, DX, 1, 3, 4, 4));   // g

        // Colons sit in column 5 of every odd digit except the last one.
        if ((k % 2 == 1) && (k < NUM_DIGITS - 1)) begin : g_colon
            assign w_colon_hit = r_sep_en & ~r_blink_phase &
                                 (in_box(bus.pos_x, bus.pos_y, DX, 5, 5, 2, 2) |
                                  in_box(bus.pos_x, bus.pos_y, DX, 5, 5, 6, 6));
        end else begin : g_no_colon
            assign w_colon_hit = 1'b0;
        end

        assign w_hit[k] = w_seg_hit | w_colon_hit;
    end

    // ---------------- two-stage pixel pipeline ----------------
    logic [NUM_DIGITS-1:0] r_s1_hit;
    logic                  r_s1_vis;
    logic [COLOR_W-1:0]    w_red, w_grn, w_blu;
    logic [COLOR_W-1:0]    r_red, r_grn, r_blu;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_red = '0;
        w_grn = '0;
        w_blu = '0;
        if (r_s1_vis) begin
            if (|r_s1_hit) begin
                w_red = FG_R;
                w_grn = FG_G;
                w_blu = FG_B;
            end else begin
                w_red = BG_R;
                w_grn = BG_G;
                w_blu = BG_B;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_hit <= '0;
            r_s1_vis <= 1'b0;
            r_red    <= '0;
            r_grn    <= '0;
            r_blu    <= '0;
        end else begin
            r_s1_hit <= w_hit;
            r_s1_vis <= bus.h_disp & bus.v_disp;
            r_red    <= w_red;
            r_grn    <= w_grn;
            r_blu    <= w_blu;
        end
    end

    assign bus.r_out = r_red;
    assign bus.g_out = r_grn;
    assign bus.b_out = r_blu;

endmodule
